pipelined_decode: RTL and testbench
===================================

# pipelined_decode

Registered, hazard-checked decode stage for the vector CPU. It holds the scalar and vector register files with write-back bypass and a per-register scoreboard. It accepts one instruction per cycle from fetch over a valid/ready handshake and stalls on RAW/WAW hazards. It presents a registered operand bundle to execute over a second valid/ready handshake.

## Interface
- DATA_WIDTH, 19: scalar register / immediate width (≥19)
- WIDTH, 8: vector element width
- VECTOR_SIZE, 8: lanes per vector register
- REGNUM, 16: registers per file (scalar and vector)
- ADDRESS_WIDTH, 4: register address width, log2(REGNUM)
- OPCODE_WIDTH, 5: opcode width
- INSTRUCTION_WIDTH, 32: instruction width
- clock  in  1  sole clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- inValid / inReady  in / out  1  fetch handshake
- instruction  in  INSTRUCTION_WIDTH  fields: opcode [31:27], rd [26:23], rs1 [22:19], rs2 [17:14], imm [18:0]
- flush  in  1  discard the output register contents
- writeEnableScalar, writeEnableVector  in  1  write-back enables; both may be high together
- writeAddress  in  ADDRESS_WIDTH  write-back destination
- writeScalarData  in  DATA_WIDTH;  writeVectorData  in  VECTOR_SIZE×WIDTH
- outValid / outReady  out / in  1  execute handshake
- opcode  out  OPCODE_WIDTH;  isVector  out  1 (= opcode[4])
- regDestinationAddress, reg1Address, reg2Address  out  ADDRESS_WIDTH
- inmediate  out  DATA_WIDTH  imm zero-extended
- reg1ScalarContent, reg2ScalarContent  out  DATA_WIDTH
- reg1VectorContent, reg2VectorContent  out  VECTOR_SIZE×WIDTH

## Operation
- Opcode classes:
  - opcode==0 is NOP: reads nothing, writes nothing.
  - opcode[3]==1: reads rs1/rs2, no rd write.
  - Otherwise: reads rs1/rs2 and writes rd.
  - opcode[4] selects the file (vector=1) used for the hazard check and for the write-back expectation.
- Register files: synchronous write on rising edge; combinational read. Same-cycle bypass applies when writeEnable is set and writeAddress equals the read address: the read returns the write data.
- Scoreboard: one pending bit per register per file.
  - A bit is set when an rd-writing instruction leaves the output register (outValid && outReady).
  - A bit is cleared by the matching writeEnable* and writeAddress.
  - If set and clear hit the same bit in the same cycle, set wins.
- Hazard (stall) conditions, for a non-NOP instruction, checked in the instruction's file:
  - rs1 or rs2 pending, or
  - rd pending (rd-writers only), or
  - the output register is valid, rd-writing, same file, and its rd equals rs1, rs2 or rd.
  - A same-cycle write-back to a register masks its pending bit. It does not mask the output-register match.
- inReady = (!outValid || outReady) && !hazard. inReady may depend on instruction. inValid must not depend on inReady.
- Accept (inValid && inReady): on the next edge the output register loads fields plus bypassed operand reads, and outValid=1.
- If outReady && !accept, then outValid goes to 0.
- flush: outValid is 0 on the next edge and the held instruction never sets the scoreboard. Existing pending bits are kept, because in-flight ops still write back. flush overrides a same-cycle accept, and inReady is forced to 0 while flush is asserted.
- Reset: both register files, the scoreboard, outValid and all output fields are 0.

## Timing
- Latency: 1 cycle from accept to outValid.
- Throughput: 1 instruction per cycle when hazard-free and outReady is held high.
- Output fields are stable while outValid && !outReady.
- Back-to-back dependent instructions: the consumer stalls until the producer's write-back. On the write-back cycle the consumer is accepted with bypassed data, so it can issue that same cycle.
- Reset is asserted mid-stall or mid-handshake: all state clears immediately (asynchronously). inReady is 1 after reset while no hazard exists.

## Test plan
- Reset, then write scalar r2=0x1234 and vector v5 with lanes 0..7 = 8'h10..8'h17. Issue scalar rs1=2 and vector rs1=5 reads → the output bundle shows exact values, outValid one cycle after accept.
- Issue scalar ADD rd=3 (accepted, then handed to execute), then a reader with rs1=3 → inReady=0 until writeEnableScalar with address 3 and data 0x55. On that cycle the reader is accepted and reg1ScalarContent=0x55.
- A vector writer to v4 is pending, then a scalar reader of r4 → no stall, because the files are independent.
- Hold outReady=0 with outValid=1 for 3 cycles → fields unchanged, inReady=0. Release → the next instruction loads on the following edge.
- flush with a held rd=7 writer, then a reader of r7 → accepted immediately (no stale pending bit).
- Assert reset while the scoreboard has bits pending and outValid=1 → all outputs 0, and the first post-reset reader of any register is accepted without stall.

Source files
------------

// File: rtl/pipelined_decode.sv
// Decode stage: scalar/vector register files with write-back bypass, per-register
// scoreboard, RAW/WAW stall logic and a registered operand bundle for execute.
module pipelined_decode #(
    parameter int DATA_WIDTH        = 19,
    parameter int WIDTH             = 8,
    parameter int VECTOR_SIZE       = 8,
    parameter int REGNUM            = 16,
    parameter int ADDRESS_WIDTH     = 4,
    parameter int OPCODE_WIDTH      = 5,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            inValid,
    output logic                            inReady,
    input  logic [INSTRUCTION_WIDTH-1:0]    instruction,
    input  logic                            flush,
    input  logic                            writeEnableScalar,
    input  logic                            writeEnableVector,
    input  logic [ADDRESS_WIDTH-1:0]        writeAddress,
    input  logic [DATA_WIDTH-1:0]           writeScalarData,
    input  logic [VECTOR_SIZE*WIDTH-1:0]    writeVectorData,
    output logic                            outValid,
    input  logic                            outReady,
    output logic [OPCODE_WIDTH-1:0]         opcode,
    output logic                            isVector,
    output logic [ADDRESS_WIDTH-1:0]        regDestinationAddress,
    output logic [ADDRESS_WIDTH-1:0]        reg1Address,
    output logic [ADDRESS_WIDTH-1:0]        reg2Address,
    output logic [DATA_WIDTH-1:0]           inmediate,
    output logic [DATA_WIDTH-1:0]           reg1ScalarContent,
    output logic [DATA_WIDTH-1:0]           reg2ScalarContent,
    output logic [VECTOR_SIZE*WIDTH-1:0]    reg1VectorContent,
    output logic [VECTOR_SIZE*WIDTH-1:0]    reg2VectorContent
);

    localparam int VW = VECTOR_SIZE * WIDTH;

    logic [DATA_WIDTH-1:0]    scalar_rf [REGNUM];
    logic [VW-1:0]            vector_rf [REGNUM];
    logic [REGNUM-1:0]        pend_scalar;
    logic [REGNUM-1:0]        pend_vector;

    logic [OPCODE_WIDTH-1:0]  in_op;
    logic [ADDRESS_WIDTH-1:0] in_rd;
    logic [ADDRESS_WIDTH-1:0] in_rs1;
    logic [ADDRESS_WIDTH-1:0] in_rs2;
    logic [DATA_WIDTH-1:0]    in_imm;
    logic                     in_nop;
    logic                     in_writes;
    logic                     in_vec;

    logic [DATA_WIDTH-1:0]    rs1_scalar;
    logic [DATA_WIDTH-1:0]    rs2_scalar;
    logic [VW-1:0]            rs1_vector;
    logic [VW-1:0]            rs2_vector;

    logic [REGNUM-1:0]        clr_scalar;
    logic [REGNUM-1:0]        clr_vector;
    logic [REGNUM-1:0]        set_scalar;
    logic [REGNUM-1:0]        set_vector;
    logic [REGNUM-1:0]        pend_file;
    logic                     out_writes;
    logic                     out_match;
    logic                     hazard;
    logic                     accept;

    assign in_op      = instruction[31:27];
    assign in_rd      = instruction[26:23];
    assign in_rs1     = instruction[22:19];
    assign in_rs2     = instruction[17:14];
    assign in_imm     = DATA_WIDTH'(instruction[18:0]);
    assign in_nop     = (in_op == '0);
    assign in_writes  = !in_nop && !in_op[3];
    assign in_vec     = in_op[OPCODE_WIDTH-1];

    assign isVector   = opcode[OPCODE_WIDTH-1];
    assign out_writes = (opcode != '0) && !opcode[3];

    // Combinational reads with same-cycle write-back bypass
    always_comb begin
        rs1_scalar = scalar_rf[in_rs1];
        rs2_scalar = scalar_rf[in_rs2];
        rs1_vector = vector_rf[in_rs1];
        rs2_vector = vector_rf[in_rs2];
        if (writeEnableScalar && writeAddress == in_rs1) rs1_scalar = writeScalarData;
        if (writeEnableScalar && writeAddress == in_rs2) rs2_scalar = writeScalarData;
        if (writeEnableVector && writeAddress == in_rs1) rs1_vector = writeVectorData;
        if (writeEnableVector && writeAddress == in_rs2) rs2_vector = writeVectorData;
    end

    always_comb begin
        clr_scalar = '0;
        clr_vector = '0;
        set_scalar = '0;
        set_vector = '0;
        if (writeEnableScalar) clr_scalar = REGNUM'(1) << writeAddress;
        if (writeEnableVector) clr_vector = REGNUM'(1) << writeAddress;
        // A flushed bundle is dropped, so it must not reserve its destination
        if (outValid && outReady && !flush && out_writes) begin
            if (isVector) set_vector = REGNUM'(1) << regDestinationAddress;
            else          set_scalar = REGNUM'(1) << regDestinationAddress;
        end
    end

    // Write-back masks the pending bit but not the output-register match
    always_comb begin
        pend_file = in_vec ? (pend_vector & ~clr_vector) : (pend_scalar & ~clr_scalar);
        out_match = outValid && out_writes && (isVector == in_vec) &&
                    ((regDestinationAddress == in_rs1) ||
                     (regDestinationAddress == in_rs2) ||
                     (in_writes && regDestinationAddress == in_rd));
        hazard    = !in_nop && (pend_file[in_rs1] || pend_file[in_rs2] ||
                                (in_writes && pend_file[in_rd]) || out_match);
        inReady   = (!outValid || outReady) && !hazard && !flush;
        accept    = inValid && inReady;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < REGNUM; i++) begin
                scalar_rf[i] <= '0;
                vector_rf[i] <= '0;
            end
        end else begin
            if (writeEnableScalar) scalar_rf[writeAddress] <= writeScalarData;
            if (writeEnableVector) vector_rf[writeAddress] <= writeVectorData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_scalar <= '0;
            pend_vector <= '0;
        end else begin
            pend_scalar <= (pend_scalar & ~clr_scalar) | set_scalar;
            pend_vector <= (pend_vector & ~clr_vector) | set_vector;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outValid              <= 1'b0;
            opcode                <= '0;
            regDestinationAddress <= '0;
            reg1Address           <= '0;
            reg2Address           <= '0;
            inmediate             <= '0;
            reg1ScalarContent     <= '0;
            reg2ScalarContent     <= '0;
            reg1VectorContent     <= '0;
            reg2VectorContent     <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (accept) begin
            outValid              <= 1'b1;
            opcode                <= in_op;
            regDestinationAddress <= in_rd;
            reg1Address           <= in_rs1;
            reg2Address           <= in_rs2;
            inmediate             <= in_imm;
            reg1ScalarContent     <= rs1_scalar;
            reg2ScalarContent     <= rs2_scalar;
            reg1VectorContent     <= rs1_vector;
            reg2VectorContent     <= rs2_vector;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_decode.sv
// Directed self-checking bench for pipelined_decode: read-back, stalls, file
// independence, back-pressure, flush and mid-operation reset.
module tb_pipelined_decode;

    localparam int DW = 19;
    localparam int VW = 64;
    localparam logic [4:0] OP_SADD = 5'b00001;
    localparam logic [4:0] OP_SRD  = 5'b01000;
    localparam logic [4:0] OP_VADD = 5'b10001;
    localparam logic [4:0] OP_VRD  = 5'b11000;

    logic          clock = 1'b0;
    logic          reset;
    logic          inValid;
    logic          inReady;
    logic [31:0]   instruction;
    logic          flush;
    logic          writeEnableScalar;
    logic          writeEnableVector;
    logic [3:0]    writeAddress;
    logic [DW-1:0] writeScalarData;
    logic [VW-1:0] writeVectorData;
    logic          outValid;
    logic          outReady;
    logic [4:0]    opcode;
    logic          isVector;
    logic [3:0]    regDestinationAddress;
    logic [3:0]    reg1Address;
    logic [3:0]    reg2Address;
    logic [DW-1:0] inmediate;
    logic [DW-1:0] reg1ScalarContent;
    logic [DW-1:0] reg2ScalarContent;
    logic [VW-1:0] reg1VectorContent;
    logic [VW-1:0] reg2VectorContent;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    pipelined_decode #(
        .DATA_WIDTH(19), .WIDTH(8), .VECTOR_SIZE(8), .REGNUM(16),
        .ADDRESS_WIDTH(4), .OPCODE_WIDTH(5), .INSTRUCTION_WIDTH(32)
    ) dut (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
        .instruction(instruction), .flush(flush),
        .writeEnableScalar(writeEnableScalar), .writeEnableVector(writeEnableVector),
        .writeAddress(writeAddress), .writeScalarData(writeScalarData),
        .writeVectorData(writeVectorData), .outValid(outValid), .outReady(outReady),
        .opcode(opcode), .isVector(isVector),
        .regDestinationAddress(regDestinationAddress), .reg1Address(reg1Address),
        .reg2Address(reg2Address), .inmediate(inmediate),
        .reg1ScalarContent(reg1ScalarContent), .reg2ScalarContent(reg2ScalarContent),
        .reg1VectorContent(reg1VectorContent), .reg2VectorContent(reg2VectorContent)
    );

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 14'h0};
    endfunction

    function automatic logic [31:0] mk_imm(input logic [4:0] op, input logic [3:0] rd,
                                           input logic [3:0] rs1, input logic [18:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        checks++; if (outValid !== 1'b0) $display("FAIL rst_valid got=%0h exp=0", outValid); else passes++;
        checks++; if (opcode !== 5'h0) $display("FAIL rst_opcode got=%0h exp=0", opcode); else passes++;
        checks++; if (reg1VectorContent !== 64'h0) $display("FAIL rst_vec got=%0h exp=0", reg1VectorContent); else passes++;
        checks++; if (inReady !== 1'b1) $display("FAIL rst_ready got=%0h exp=1", inReady); else passes++;
        @(negedge clock);
        reset = 1'b0;
        step();
    endtask

    task automatic test_readback;
        writeEnableScalar = 1'b1; writeAddress = 4'd2; writeScalarData = 19'h1234;
        step();
        writeEnableScalar = 1'b0;
        writeEnableVector = 1'b1; writeAddress = 4'd5; writeVectorData = 64'h1716151413121110;
        step();
        writeEnableVector = 1'b0;
        outReady = 1'b1; inValid = 1'b1; instruction = mk(OP_SRD, 4'd0, 4'd2, 4'd0);
        #1;
        checks++; if (inReady !== 1'b1) $display("FAIL rb_ready got=%0h exp=1", inReady); else passes++;
        step();
        checks++; if (outValid !== 1'b1) $display("FAIL rb_valid got=%0h exp=1", outValid); else passes++;
        checks++; if (reg1ScalarContent !== 19'h1234) $display("FAIL rb_scalar got=%0h exp=1234", reg1ScalarContent); else passes++;
        checks++; if (opcode !== OP_SRD) $display("FAIL rb_opcode got=%0h exp=%0h", opcode, OP_SRD); else passes++;
        checks++; if (reg1Address !== 4'd2) $display("FAIL rb_addr got=%0h exp=2", reg1Address); else passes++;
        instruction = mk(OP_VRD, 4'd0, 4'd5, 4'd5);
        #1;
        checks++; if (inReady !== 1'b1) $display("FAIL b2b_ready got=%0h exp=1", inReady); else passes++;
        step();
        checks++; if (reg1VectorContent !== 64'h1716151413121110) $display("FAIL rb_vec1 got=%0h exp=1716151413121110", reg1VectorContent); else passes++;
        checks++; if (reg2VectorContent !== 64'h1716151413121110) $display("FAIL rb_vec2 got=%0h exp=1716151413121110", reg2VectorContent); else passes++;
        checks++; if (isVector !== 1'b1) $display("FAIL rb_isvec got=%0h exp=1", isVector); else passes++;
        instruction = mk_imm(OP_SRD, 4'd0, 4'd2, 19'h5ABCD);
        step();
        checks++; if (inmediate !== 19'h5ABCD) $display("FAIL rb_imm got=%0h exp=5abcd", inmediate); else passes++;
        checks++; if (reg2Address !== 4'd6) $display("FAIL rb_rs2 got=%0h exp=6", reg2Address); else passes++;
        checks++; if (isVector !== 1'b0) $display("FAIL rb_isscal got=%0h exp=0", isVector); else passes++;
        inValid = 1'b0;
        step();
        checks++; if (outValid !== 1'b0) $display("FAIL rb_drain got=%0h exp=0", outValid); else passes++;
    endtask

    task automatic test_raw_stall;
        outReady = 1'b1; inValid = 1'b1; instruction = mk(OP_SADD, 4'd3, 4'd1, 4'd1);
        #1;
        checks++; if (inReady !== 1'b1) $display("FAIL raw_wr_ready got=%0h exp=1", inReady); else passes++;
        step();
        instruction = mk(OP_SRD, 4'd0, 4'd3, 4'd0);
        #1;
        checks++; if (inReady !== 1'b0) $display("FAIL raw_outmatch got=%0h exp=0", inReady); else passes++;
        step();
        checks++; if (inReady !== 1'b0) $display("FAIL raw_pend1 got=%0h exp=0", inReady); else passes++;
        checks++; if (outValid !== 1'b0) $display("FAIL raw_bubble got=%0h exp=0", outValid); else passes++;
        step();
        checks++; if (inReady !== 1'b0) $display("FAIL raw_pend2 got=%0h exp=0", inReady); else passes++;
        writeEnableScalar = 1'b1; writeAddress = 4'd3; writeScalarData = 19'h55;
        #1;
        checks++; if (inReady !== 1'b1) $display("FAIL raw_wb_ready got=%0h exp=1", inReady); else passes++;
        step();
        writeEnableScalar = 1'b0; inValid = 1'b0;
        checks++; if (outValid !== 1'b1) $display("FAIL raw_valid got=%0h exp=1", outValid); else passes++;
        checks++; if (reg1ScalarContent !== 19'h55) $display("FAIL raw_bypass got=%0h exp=55", reg1ScalarContent); else passes++;
        step();
    endtask

    task automatic test_file_independence;
        outReady = 1'b1; inValid = 1'b1; instruction = mk(OP_VADD, 4'd4, 4'd0, 4'd0);
        step();
        instruction = mk(OP_SRD, 4'd0, 4'd4, 4'd4);
        #1;
        checks++; if (inReady !== 1'b1) $display("FAIL ind_ready got=%0h exp=1", inReady); else passes++;
        step();
        checks++; if (outValid !== 1'b1) $display("FAIL ind_valid got=%0h exp=1", outValid); else passes++;
        checks++; if (isVector !== 1'b0) $display("FAIL ind_isvec got=%0h exp=0", isVector); else passes++;
        checks++; if (reg1Address !== 4'd4) $display("FAIL ind_addr got=%0h exp=4", reg1Address); else passes++;
        instruction = mk(OP_VRD, 4'd0, 4'd4, 4'd4);
        #1;
        checks++; if (inReady !== 1'b0) $display("FAIL ind_vstall got=%0h exp=0", inReady); else passes++;
        writeEnableVector = 1'b1; writeAddress = 4'd4; writeVectorData = 64'hA5A5_0102_0304_5A5A;
        #1;
        checks++; if (inReady !== 1'b1) $display("FAIL ind_vwb_ready got=%0h exp=1", inReady); else passes++;
        step();
        writeEnableVector = 1'b0; inValid = 1'b0;
        checks++; if (reg1VectorContent !== 64'hA5A5_0102_0304_5A5A) $display("FAIL ind_vbypass got=%0h exp=a5a501020304 5a5a", reg1VectorContent); else passes++;
        step();
    endtask

    task automatic test_backpressure;
        outReady = 1'b0; inValid = 1'b1; instruction = mk(OP_SRD, 4'd0, 4'd2, 4'd0);
        step();
        instruction = mk(OP_SRD, 4'd0, 4'd3, 4'd0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (outValid !== 1'b1) $display("FAIL bp_valid[%0d] got=%0h exp=1", i, outValid); else passes++;
            checks++; if (reg1Address !== 4'd2) $display("FAIL bp_addr[%0d] got=%0h exp=2", i, reg1Address); else passes++;
            checks++; if (reg1ScalarContent !== 19'h1234) $display("FAIL bp_data[%0d] got=%0h exp=1234", i, reg1ScalarContent); else passes++;
            checks++; if (inReady !== 1'b0) $display("FAIL bp_ready[%0d] got=%0h exp=0", i, inReady); else passes++;
            step();
        end
        outReady = 1'b1;
        #1;
        checks++; if (inReady !== 1'b1) $display("FAIL bp_release got=%0h exp=1", inReady); else passes++;
        step();
        checks++; if (reg1Address !== 4'd3) $display("FAIL bp_next_addr got=%0h exp=3", reg1Address); else passes++;
        checks++; if (reg1ScalarContent !== 19'h55) $display("FAIL bp_next_data got=%0h exp=55", reg1ScalarContent); else passes++;
        inValid = 1'b0;
        step();
    endtask

    task automatic test_flush;
        outReady = 1'b0; inValid = 1'b1; instruction = mk(OP_SADD, 4'd7, 4'd0, 4'd0);
        step();
        inValid = 1'b0; flush = 1'b1; outReady = 1'b1;
        #1;
        checks++; if (inReady !== 1'b0) $display("FAIL fl_ready got=%0h exp=0", inReady); else passes++;
        step();
        flush = 1'b0;
        checks++; if (outValid !== 1'b0) $display("FAIL fl_valid got=%0h exp=0", outValid); else passes++;
        inValid = 1'b1; instruction = mk(OP_SRD, 4'd0, 4'd7, 4'd0);
        #1;
        checks++; if (inReady !== 1'b1) $display("FAIL fl_nostale got=%0h exp=1", inReady); else passes++;
        step();
        checks++; if (outValid !== 1'b1) $display("FAIL fl_accept got=%0h exp=1", outValid); else passes++;
        checks++; if (reg1Address !== 4'd7) $display("FAIL fl_addr got=%0h exp=7", reg1Address); else passes++;
        inValid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid;
        outReady = 1'b1; inValid = 1'b1; instruction = mk(OP_SADD, 4'd9, 4'd0, 4'd0);
        step();
        instruction = mk(OP_SADD, 4'd10, 4'd0, 4'd0);
        #1;
        checks++; if (inReady !== 1'b1) $display("FAIL rm_ready got=%0h exp=1", inReady); else passes++;
        step();
        inValid = 1'b0; outReady = 1'b0;
        checks++; if (regDestinationAddress !== 4'd10) $display("FAIL rm_held got=%0h exp=a", regDestinationAddress); else passes++;
        #1;
        reset = 1'b1;
        #1;
        checks++; if (outValid !== 1'b0) $display("FAIL rm_valid got=%0h exp=0", outValid); else passes++;
        checks++; if (regDestinationAddress !== 4'd0) $display("FAIL rm_rd got=%0h exp=0", regDestinationAddress); else passes++;
        checks++; if (opcode !== 5'd0) $display("FAIL rm_opcode got=%0h exp=0", opcode); else passes++;
        checks++; if (inmediate !== 19'd0) $display("FAIL rm_imm got=%0h exp=0", inmediate); else passes++;
        #3;
        reset = 1'b0;
        inValid = 1'b1; outReady = 1'b1; instruction = mk(OP_SRD, 4'd0, 4'd9, 4'd2);
        #1;
        checks++; if (inReady !== 1'b1) $display("FAIL rm_post_ready got=%0h exp=1", inReady); else passes++;
        step();
        checks++; if (outValid !== 1'b1) $display("FAIL rm_post_valid got=%0h exp=1", outValid); else passes++;
        checks++; if (reg1ScalarContent !== 19'd0) $display("FAIL rm_r9 got=%0h exp=0", reg1ScalarContent); else passes++;
        checks++; if (reg2ScalarContent !== 19'd0) $display("FAIL rm_r2 got=%0h exp=0", reg2ScalarContent); else passes++;
        inValid = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; instruction = '0; flush = 1'b0;
        writeEnableScalar = 1'b0; writeEnableVector = 1'b0; writeAddress = '0;
        writeScalarData = '0; writeVectorData = '0; outReady = 1'b0;
        test_reset();
        test_readback();
        test_raw_stall();
        test_file_independence();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
